// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I sequencer types, opcode constants and reset vector
package rv32i_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } pcseq_state_t;

    typedef enum logic [1:0] {
        PLUS4  = 2'd0,
        BRANCH = 2'd1,
        JALR   = 2'd2
    } pc_sel_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h01000000;

    // True for opcodes that write a destination register at writeback.
    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP: writes_rd = 1'b1;
            default:                     writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC target and misalignment flag
import rv32i_pkg::*;

module pc_next_calc (
    input  pc_sel_t     sel,
    input  logic [31:0] current_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] target,
    output logic        misaligned
);

    // Target select; all sums wrap modulo 2^32, JALR clears bit 0.
    always_comb begin
        target = current_pc + 32'd4;
        case (sel)
            BRANCH:  target = current_pc + imm;
            JALR:    target = (rs1_val + imm) & ~32'h1;
            default: target = current_pc + 32'd4;
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle RV32I control sequencer (option: PC_MISALIGN_TRAP_EN)
import rv32i_pkg::*;

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    input  logic        instr_valid,
    input  logic [6:0]  opcode,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic [31:0] next_pc,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        mem_req,
    output logic [2:0]  state,
    output logic        halted,
    output logic        trap
);

    pcseq_state_t state_q;
    pcseq_state_t state_nxt;
    pc_sel_t      sel;
    logic [31:0]  target;
    logic         misaligned;
    logic         trap_now;

    // Choose which target the PC will take for the instruction in the IR.
    always_comb begin
        sel = PLUS4;
        case (opcode)
            OPC_JAL:    sel = BRANCH;
            OPC_BRANCH: sel = branch_taken ? BRANCH : PLUS4;
            OPC_JALR:   sel = JALR;
            default:    sel = PLUS4;
        endcase
    end

    pc_next_calc u_calc (
        .sel        (sel),
        .current_pc (current_pc),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .target     (target),
        .misaligned (misaligned)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;

    assign trap_now = (state_q == WB) && misaligned;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else if (trap_now) begin
            trap_q <= 1'b1;
        end
    end

    assign trap    = trap_q;
    assign next_pc = reset ? RESET_PC : target;
`else
    assign trap_now = 1'b0;
    assign trap     = 1'b0;
    // A misaligned target is silently aligned down to a word boundary.
    assign next_pc  = reset ? RESET_PC
                    : (misaligned ? {target[31:2], 2'b00} : target);
`endif

    // State register; reset has priority over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            FETCH:   if (instr_valid) state_nxt = DECODE;
            DECODE:  state_nxt = (opcode == OPC_SYSTEM) ? HALT : EXEC;
            EXEC:    state_nxt = (opcode == OPC_LOAD || opcode == OPC_STORE) ? MEM : WB;
            MEM:     if (mem_ready) state_nxt = WB;
            WB:      state_nxt = trap_now ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes decoded from registered state; ir_we also needs instr_valid.
    always_comb begin
        pc_we   = (state_q == WB) && !trap_now;
        rf_we   = (state_q == WB) && !trap_now && writes_rd(opcode);
        mem_req = (state_q == MEM);
        ir_we   = (state_q == FETCH) && instr_valid && !reset;
        halted  = (state_q == HALT);
        state   = state_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        branch_taken;
    logic        mem_ready;
    logic [31:0] next_pc;
    logic        pc_we;
    logic        ir_we;
    logic        rf_we;
    logic        mem_req;
    logic [2:0]  state;
    logic        halted;
    logic        trap;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .current_pc   (current_pc),
        .instr_valid  (instr_valid),
        .opcode       (opcode),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .next_pc      (next_pc),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .rf_we        (rf_we),
        .mem_req      (mem_req),
        .state        (state),
        .halted       (halted),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH; reports the cycle in which pc_we
    // was seen (0 if never), the next_pc/rf_we captured there and the
    // number of cycles mem_req was high.
    task automatic run_instr(input logic [6:0] opc, input logic [31:0] pc,
                             input logic [31:0] imm_v, input logic [31:0] rs1_v,
                             input logic tk, input int waits,
                             output int wb_cyc, output logic [31:0] npc,
                             output logic rfw, output int mreq_cyc);
        int mc;
        current_pc   = pc;
        opcode       = opc;
        imm          = imm_v;
        rs1_val      = rs1_v;
        branch_taken = tk;
        instr_valid  = 1'b1;
        mem_ready    = 1'b0;
        wb_cyc = 0; npc = '0; rfw = 1'b0; mreq_cyc = 0; mc = 0;
        for (int c = 1; c <= 30; c++) begin
            if (state == 3'd3) begin
                mem_ready = (mc >= waits);
                mc++;
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (halted) break;
            if (mem_req) mreq_cyc++;
            if (pc_we) begin
                wb_cyc = c;
                npc    = next_pc;
                rfw    = rf_we;
            end
            tick();
            if (wb_cyc != 0) break;
        end
        mem_ready = 1'b0;
    endtask

    int          wb;
    int          mq;
    logic [31:0] np;
    logic        rw;

    initial begin
        reset = 1'b1; current_pc = 32'h0; instr_valid = 1'b0; opcode = 7'h0;
        imm = 32'h0; rs1_val = 32'h0; branch_taken = 1'b0; mem_ready = 1'b0;
        tick();
        instr_valid = 1'b1;
        tick();
        check("rst_next_pc", next_pc, 32'h01000000);
        check("rst_state",   {29'd0, state}, 32'd0);
        check("rst_strobes", {26'd0, pc_we, ir_we, rf_we, mem_req, halted, trap}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ir_we", {31'd0, ir_we}, 32'd1);

        run_instr(7'b0010011, 32'h01000000, 32'h0, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("opimm_cyc", wb, 4);
        check("opimm_npc", np, 32'h01000004);
        check("opimm_rf",  {31'd0, rw}, 32'd1);

        run_instr(7'b1100011, 32'h01000010, 32'hFFFFFFF8, 32'h0, 1'b1, 0, wb, np, rw, mq);
        check("br_t_cyc", wb, 4);
        check("br_t_npc", np, 32'h01000008);
        check("br_t_rf",  {31'd0, rw}, 32'd0);

        run_instr(7'b1100011, 32'h01000010, 32'hFFFFFFF8, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("br_nt_npc", np, 32'h01000014);

        run_instr(7'b1100111, 32'h01000020, 32'h00000004, 32'h01000101, 1'b0, 0, wb, np, rw, mq);
        check("jalr_npc", np, 32'h01000104);
        check("jalr_rf",  {31'd0, rw}, 32'd1);

        run_instr(7'b0000011, 32'h01000030, 32'h0, 32'h0, 1'b0, 3, wb, np, rw, mq);
        check("load_cyc",  wb, 8);
        check("load_mreq", mq, 4);
        check("load_npc",  np, 32'h01000034);
        check("load_rf",   {31'd0, rw}, 32'd1);

        run_instr(7'b0100011, 32'h01000040, 32'h0, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("store_cyc", wb, 5);
        check("store_rf",  {31'd0, rw}, 32'd0);

        run_instr(7'b0001111, 32'h01000050, 32'h00000100, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("fence_npc", np, 32'h01000054);
        check("fence_rf",  {31'd0, rw}, 32'd0);

        run_instr(7'b1101111, 32'hFFFFFFFC, 32'h00000008, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("jal_wrap_npc", np, 32'h00000004);
        check("jal_wrap_rf",  {31'd0, rw}, 32'd1);

        // Reset while a data request is outstanding.
        opcode = 7'b0000011; current_pc = 32'h01000060; instr_valid = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick();
        check("mem_state",   {29'd0, state}, 32'd3);
        check("mem_req_on",  {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("mem_rst_npc", next_pc, 32'h01000000);
        tick();
        check("mem_req_off", {31'd0, mem_req}, 32'd0);
        check("mem_rst_st",  {29'd0, state}, 32'd0);
        reset = 1'b0;

`ifdef PC_MISALIGN_TRAP_EN
        run_instr(7'b1100111, 32'h01000070, 32'h00000004, 32'h01000102, 1'b0, 0, wb, np, rw, mq);
        check("trap_no_pcwe", wb, 0);
        check("trap_flag",    {31'd0, trap}, 32'd1);
        check("trap_state",   {29'd0, state}, 32'd5);
        reset = 1'b1;
        tick();
        check("trap_cleared", {31'd0, trap}, 32'd0);
        reset = 1'b0;
`else
        run_instr(7'b1100111, 32'h01000070, 32'h00000004, 32'h01000102, 1'b0, 0, wb, np, rw, mq);
        check("misal_npc",  np, 32'h01000104);
        check("misal_trap", {31'd0, trap}, 32'd0);
`endif

        run_instr(7'b1110011, 32'h01000080, 32'h0, 32'h0, 1'b0, 0, wb, np, rw, mq);
        check("ecall_no_pcwe", wb, 0);
        check("ecall_halted",  {31'd0, halted}, 32'd1);
        check("ecall_state",   {29'd0, state}, 32'd5);
        instr_valid = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_strobes", {28'd0, pc_we, ir_we, rf_we, mem_req}, 32'd0);
        end
        check("halt_stays", {29'd0, state}, 32'd5);
        reset = 1'b1;
        tick();
        check("halt_reset", {31'd0, halted}, 32'd0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
